// File: rtl/icache_fetch_resp.sv
// Instruction-side responder: holds the loader-filled I-cache word array and
// returns one instruction per cycle for the PC, with stall/done back to the PC.
module icache_fetch_resp #(
    parameter int          INDEX_W   = 12,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic               ip_clk,
    input  logic               ip_rst,
    input  logic [31:0]        ip_pc,
    input  logic               ip_flush,
    input  logic               ip_hold,
    input  logic               ip_load_start,
    input  logic               ip_load_valid,
    input  logic [31:0]        ip_load_addr,
    input  logic [31:0]        ip_load_data,
    input  logic               ip_load_done,
    output logic               op_load_ready,
    output logic [INDEX_W:0]   op_load_count,
    output logic               op_load_err,
    output logic [31:0]        op_instr,
    output logic [31:0]        op_instr_pc,
    output logic               op_instr_valid,
    output logic               op_stall_ctrl,
    output logic               op_done,
    output logic [1:0]         op_state
);

    localparam int               DEPTH     = 1 << INDEX_W;
    localparam logic [INDEX_W:0] COUNT_MAX = (INDEX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    logic [31:0]        mem [DEPTH];
    logic               pc_oor;
    logic               load_oor;
    logic [INDEX_W-1:0] pc_idx;
    logic [INDEX_W-1:0] load_idx;
    logic               load_wr;
    logic               unused_byte_bits;

    assign pc_oor   = |ip_pc[31:INDEX_W+2];
    assign load_oor = |ip_load_addr[31:INDEX_W+2];
    assign pc_idx   = ip_pc[INDEX_W+1:2];
    assign load_idx = ip_load_addr[INDEX_W+1:2];
    assign unused_byte_bits = ^{ip_pc[1:0], ip_load_addr[1:0]};

    // load_start outranks everything, including a load word arriving with it
    assign load_wr = (state == ST_LOAD) && ip_load_valid && !ip_load_start
                     && !load_oor && !ip_rst;

    assign op_load_ready = (state == ST_LOAD);
    assign op_stall_ctrl = (state != ST_RUN) | ip_hold | pc_oor;
    assign op_state      = state;

    // Array has no reset: program contents survive a reset
    always_ff @(posedge ip_clk) begin
        if (load_wr) begin
            mem[load_idx] <= ip_load_data;
        end
    end

    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            state          <= ST_LOAD;
            op_instr       <= NOP_INSTR;
            op_instr_pc    <= 32'd0;
            op_instr_valid <= 1'b0;
            op_load_count  <= '0;
            op_load_err    <= 1'b0;
            op_done        <= 1'b0;
        end else if (ip_load_start) begin
            state          <= ST_LOAD;
            op_instr       <= NOP_INSTR;
            op_instr_valid <= 1'b0;
            op_load_count  <= '0;
            op_load_err    <= 1'b0;
            op_done        <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    op_instr_valid <= 1'b0;
                    op_instr       <= NOP_INSTR;
                    if (ip_load_valid) begin
                        if (load_oor) begin
                            op_load_err <= 1'b1;
                        end else if (op_load_count != COUNT_MAX) begin
                            op_load_count <= op_load_count + 1'b1;
                        end
                    end
                    if (ip_load_done) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ip_flush) begin
                        op_instr_valid <= 1'b0;
                        op_instr       <= NOP_INSTR;
                        op_instr_pc    <= ip_pc;
                    end else if (pc_oor) begin
                        op_instr_valid <= 1'b0;
                        op_instr       <= NOP_INSTR;
                        op_done        <= 1'b1;
                        state          <= ST_DONE;
                    end else if (!ip_hold) begin
                        // Word lands on the same edge the PC advances past it
                        op_instr       <= mem[pc_idx];
                        op_instr_pc    <= ip_pc;
                        op_instr_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    op_instr_valid <= 1'b0;
                    op_instr       <= NOP_INSTR;
                    op_done        <= 1'b1;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_resp.sv
// Bench for icache_fetch_resp: directed vector table, hand-written hold/flush/
// range/reset sequences, count saturation, then random traffic against a model.
module tb_icache_fetch_resp;

    localparam int          IW    = 12;
    localparam int          DEPTH = 1 << IW;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          M_LOAD = 0, M_RUN = 1, M_DONE = 2;

    logic          ip_clk, ip_rst;
    logic [31:0]   ip_pc;
    logic          ip_flush, ip_hold, ip_load_start, ip_load_valid, ip_load_done;
    logic [31:0]   ip_load_addr, ip_load_data;
    logic          op_load_ready, op_load_err, op_instr_valid, op_stall_ctrl, op_done;
    logic [IW:0]   op_load_count;
    logic [31:0]   op_instr, op_instr_pc;
    logic [1:0]    op_state;

    icache_fetch_resp #(.INDEX_W(IW), .NOP_INSTR(NOP)) dut (
        .ip_clk(ip_clk), .ip_rst(ip_rst), .ip_pc(ip_pc), .ip_flush(ip_flush),
        .ip_hold(ip_hold), .ip_load_start(ip_load_start), .ip_load_valid(ip_load_valid),
        .ip_load_addr(ip_load_addr), .ip_load_data(ip_load_data), .ip_load_done(ip_load_done),
        .op_load_ready(op_load_ready), .op_load_count(op_load_count), .op_load_err(op_load_err),
        .op_instr(op_instr), .op_instr_pc(op_instr_pc), .op_instr_valid(op_instr_valid),
        .op_stall_ctrl(op_stall_ctrl), .op_done(op_done), .op_state(op_state)
    );

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: what the PC/decode side should observe
    int          m_mode;
    int          m_count;
    logic        m_err, m_done, m_valid;
    logic [31:0] m_instr, m_ipc;
    logic [31:0] m_mem [DEPTH];

    typedef struct {
        logic        ls, lv;
        logic [31:0] la, ld;
        logic        ldone;
        logic [31:0] pc;
        int          e_count;
        logic        e_valid;
        logic [31:0] e_instr, e_ipc;
        logic        e_stall;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_LOAD; m_count = 0; m_err = 0; m_done = 0;
        m_valid = 0; m_instr = NOP; m_ipc = 0;
    endtask

    task automatic model_edge();
        bit pc_in = (ip_pc < 32'h4000);
        if (ip_rst) begin
            model_reset();
        end else if (ip_load_start) begin
            m_mode = M_LOAD; m_count = 0; m_err = 0; m_done = 0;
            m_valid = 0; m_instr = NOP;
        end else if (m_mode == M_LOAD) begin
            m_valid = 0; m_instr = NOP;
            if (ip_load_valid) begin
                if (ip_load_addr < 32'h4000) begin
                    m_mem[ip_load_addr / 4] = ip_load_data;
                    if (m_count < DEPTH) m_count++;
                end else begin
                    m_err = 1;
                end
            end
            if (ip_load_done) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (ip_flush) begin
                m_valid = 0; m_instr = NOP; m_ipc = ip_pc;
            end else if (!pc_in) begin
                m_valid = 0; m_instr = NOP; m_done = 1; m_mode = M_DONE;
            end else if (!ip_hold) begin
                m_valid = 1; m_instr = m_mem[ip_pc / 4]; m_ipc = ip_pc;
            end
        end
    endtask

    task automatic model_check();
        chk("valid", 32'(op_instr_valid), 32'(m_valid));
        chk("instr", op_instr, m_instr);
        chk("instr_pc", op_instr_pc, m_ipc);
        chk("load_count", 32'(op_load_count), 32'(m_count));
        chk("load_err", 32'(op_load_err), 32'(m_err));
        chk("done", 32'(op_done), 32'(m_done));
        chk("load_ready", 32'(op_load_ready), 32'(m_mode == M_LOAD));
        chk("stall", 32'(op_stall_ctrl),
            32'((m_mode != M_RUN) || ip_hold || (ip_pc >= 32'h4000)));
    endtask

    task automatic tick();
        model_edge();
        @(posedge ip_clk);
        #1;
        model_check();
    endtask

    task automatic idle();
        ip_flush = 0; ip_hold = 0; ip_load_start = 0; ip_load_valid = 0;
        ip_load_addr = 0; ip_load_data = 0; ip_load_done = 0;
    endtask

    task automatic expect_fetch(input string name, input logic v, input logic [31:0] ins,
                                input logic [31:0] pc);
        chk({name, "_valid"}, 32'(op_instr_valid), 32'(v));
        chk({name, "_instr"}, op_instr, ins);
        chk({name, "_pc"}, op_instr_pc, pc);
    endtask

    initial begin
        vecs[0] = '{1, 0, 32'h0, 32'h0,        0, 32'h0, 0, 0, NOP,          32'h0, 1};
        vecs[1] = '{0, 1, 32'h0, 32'h00500093, 0, 32'h0, 1, 0, NOP,          32'h0, 1};
        vecs[2] = '{0, 1, 32'h4, 32'h00100113, 0, 32'h0, 2, 0, NOP,          32'h0, 1};
        vecs[3] = '{0, 1, 32'h8, 32'h002081B3, 0, 32'h0, 3, 0, NOP,          32'h0, 1};
        vecs[4] = '{0, 1, 32'hC, 32'h00000013, 0, 32'h0, 4, 0, NOP,          32'h0, 1};
        vecs[5] = '{0, 0, 32'h0, 32'h0,        1, 32'h0, 4, 0, NOP,          32'h0, 0};
        vecs[6] = '{0, 0, 32'h0, 32'h0,        0, 32'h0, 4, 1, 32'h00500093, 32'h0, 0};
        vecs[7] = '{0, 0, 32'h0, 32'h0,        0, 32'h4, 4, 1, 32'h00100113, 32'h4, 0};
        vecs[8] = '{0, 0, 32'h0, 32'h0,        0, 32'h8, 4, 1, 32'h002081B3, 32'h8, 0};

        idle();
        ip_pc = 0;
        ip_rst = 1;
        model_reset();
        tick(); tick();
        chk("rst_instr", op_instr, NOP);
        chk("rst_pc", op_instr_pc, 32'h0);
        chk("rst_valid", 32'(op_instr_valid), 32'h0);
        chk("rst_count", 32'(op_load_count), 32'h0);
        chk("rst_err", 32'(op_load_err), 32'h0);
        chk("rst_done", 32'(op_done), 32'h0);
        ip_rst = 0;

        // Load four words, start, fetch three consecutive PCs
        for (int i = 0; i < 9; i++) begin
            idle();
            ip_load_start = vecs[i].ls; ip_load_valid = vecs[i].lv;
            ip_load_addr = vecs[i].la; ip_load_data = vecs[i].ld;
            ip_load_done = vecs[i].ldone; ip_pc = vecs[i].pc;
            tick();
            chk($sformatf("vec%0d_count", i), 32'(op_load_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_valid", i), 32'(op_instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_instr", i), op_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_pc", i), op_instr_pc, vecs[i].e_ipc);
            chk($sformatf("vec%0d_stall", i), 32'(op_stall_ctrl), 32'(vecs[i].e_stall));
        end

        // Hold for three cycles with pc 4 on the output, PC parked at 8
        idle(); ip_pc = 32'h4; tick();
        expect_fetch("pre_hold", 1, 32'h00100113, 32'h4);
        ip_hold = 1; ip_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_fetch("hold", 1, 32'h00100113, 32'h4);
            chk("hold_stall", 32'(op_stall_ctrl), 32'h1);
        end
        ip_hold = 0; tick();
        expect_fetch("post_hold", 1, 32'h002081B3, 32'h8);

        // Flush kills the fetch at pc 8; target C follows
        ip_flush = 1; tick();
        expect_fetch("flush", 0, NOP, 32'h8);
        ip_flush = 0; ip_pc = 32'hC; tick();
        expect_fetch("flush_tgt", 1, 32'h00000013, 32'hC);

        // Leaving the cache range finishes execution; load_start reopens load
        ip_pc = 32'h00004000; tick();
        chk("oor_valid", 32'(op_instr_valid), 32'h0);
        chk("oor_done", 32'(op_done), 32'h1);
        chk("oor_stall", 32'(op_stall_ctrl), 32'h1);
        ip_pc = 32'h0; tick();
        chk("done_sticky", 32'(op_done), 32'h1);
        chk("done_stall", 32'(op_stall_ctrl), 32'h1);
        ip_load_start = 1; tick();
        chk("ls_done", 32'(op_done), 32'h0);
        chk("ls_ready", 32'(op_load_ready), 32'h1);

        // Out-of-range load write is dropped and flagged
        idle(); ip_load_valid = 1; ip_load_addr = 32'h00010000; ip_load_data = 32'hDEADBEEF;
        tick();
        chk("err_flag", 32'(op_load_err), 32'h1);
        chk("err_count", 32'(op_load_count), 32'h0);
        idle(); ip_load_done = 1; tick();
        idle(); ip_pc = 32'h0; tick();
        expect_fetch("err_idx0", 1, 32'h00500093, 32'h0);

        // Reset mid-load after two words; array contents survive
        ip_load_start = 1; tick();
        idle(); ip_load_valid = 1; ip_load_addr = 32'h10; ip_load_data = 32'hAAAA0001; tick();
        ip_load_addr = 32'h14; ip_load_data = 32'hAAAA0002; tick();
        ip_load_addr = 32'h00020000; tick();
        chk("pre_rst_count", 32'(op_load_count), 32'h2);
        idle();
        #2 ip_rst = 1;
        #1 model_reset();
        chk("arst_count", 32'(op_load_count), 32'h0);
        chk("arst_err", 32'(op_load_err), 32'h0);
        chk("arst_pc", op_instr_pc, 32'h0);
        chk("arst_ready", 32'(op_load_ready), 32'h1);
        tick();
        ip_rst = 0; ip_load_done = 1; tick();
        chk("reload_count", 32'(op_load_count), 32'h0);
        idle(); ip_pc = 32'h0; tick();
        expect_fetch("retain0", 1, 32'h00500093, 32'h0);
        ip_pc = 32'h10; tick();
        expect_fetch("retain10", 1, 32'hAAAA0001, 32'h10);

        // Fill every word and one more: the count saturates
        ip_load_start = 1; tick();
        idle(); ip_load_valid = 1;
        for (int i = 0; i <= DEPTH; i++) begin
            ip_load_addr = 32'((i % DEPTH) * 4);
            ip_load_data = $urandom;
            tick();
        end
        chk("sat_count", 32'(op_load_count), 32'(DEPTH));
        idle(); ip_load_done = 1; tick();

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ip_rst        = ($urandom_range(0, 299) == 0);
            ip_load_start = ($urandom_range(0, 59) == 0);
            ip_load_valid = ($urandom_range(0, 3) != 0);
            ip_load_addr  = ($urandom_range(0, 19) == 0) ? ($urandom | 32'h4000)
                                                         : 32'($urandom_range(0, 32'h3FFF));
            ip_load_data  = $urandom;
            ip_load_done  = ($urandom_range(0, 11) == 0);
            ip_pc         = ($urandom_range(0, 49) == 0) ? ($urandom | 32'h4000)
                                                         : 32'($urandom_range(0, 32'h3FFF));
            ip_hold       = ($urandom_range(0, 4) == 0);
            ip_flush      = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
